// File: rtl/pitch_pkg.sv
// Shared constants for the BATS PITCH command builder: message codes, lengths,
// field offsets, orderbook command encodings and FSM state encoding.
package pitch_pkg;

    localparam logic [7:0] MsgAddLong    = 8'h21;
    localparam logic [7:0] MsgExecuted   = 8'h23;
    localparam logic [7:0] MsgReduceLong = 8'h25;
    localparam logic [7:0] MsgModifyLong = 8'h27;
    localparam logic [7:0] MsgDelete     = 8'h29;

    localparam logic [7:0] LenAddLong    = 8'd34;
    localparam logic [7:0] LenExecuted   = 8'd26;
    localparam logic [7:0] LenReduceLong = 8'd18;
    localparam logic [7:0] LenModifyLong = 8'd27;
    localparam logic [7:0] LenDelete     = 8'd14;

    localparam logic [7:0] CmdAdd      = 8'd0;
    localparam logic [7:0] CmdExecuted = 8'd1;
    localparam logic [7:0] CmdReduce   = 8'd2;
    localparam logic [7:0] CmdModify   = 8'd3;
    localparam logic [7:0] CmdDelete   = 8'd4;

    localparam logic [7:0] OffOrderId  = 8'd6;
    localparam logic [7:0] OffAddSide  = 8'd14;
    localparam logic [7:0] OffAddQty   = 8'd15;
    localparam logic [7:0] OffAddSym   = 8'd19;
    localparam logic [7:0] OffAddPrice = 8'd25;
    localparam logic [7:0] OffQty      = 8'd14;  // exec/cancel/modify qty
    localparam logic [7:0] OffModPrice = 8'd18;

    typedef enum logic [2:0] {
        StIdle,
        StType,
        StBody,
        StSkip,
        StResync
    } state_e;

    typedef struct packed {
        logic       ok;
        logic [7:0] cmd;
        logic [7:0] len;
    } msg_info_t;

    function automatic msg_info_t msg_lookup(input logic [7:0] code);
        msg_info_t info;
        case (code)
            MsgAddLong:    info = '{ok: 1'b1, cmd: CmdAdd,      len: LenAddLong};
            MsgExecuted:   info = '{ok: 1'b1, cmd: CmdExecuted, len: LenExecuted};
            MsgReduceLong: info = '{ok: 1'b1, cmd: CmdReduce,   len: LenReduceLong};
            MsgModifyLong: info = '{ok: 1'b1, cmd: CmdModify,   len: LenModifyLong};
            MsgDelete:     info = '{ok: 1'b1, cmd: CmdDelete,   len: LenDelete};
            default:       info = '{ok: 1'b0, cmd: 8'd0,        len: 8'd0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/pitch_le_field_capture.sv
// Assembles one little-endian field of 1-8 bytes from a byte stream, shifting in
// bytes whose position falls inside [offset, offset+nbytes).
module pitch_le_field_capture #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         accept,
    input  logic [7:0]   byte_cnt,
    input  logic [7:0]   offset,
    input  logic [3:0]   nbytes,
    input  logic [7:0]   data,
    output logic [W-1:0] field_next
);
    logic [63:0] sreg_q, sreg_d;
    logic [8:0]  win_end;
    logic        in_win;
    logic [2:0]  rem;
    logic [5:0]  shamt;

    always_comb begin
        win_end = {1'b0, offset} + {5'd0, nbytes};
        in_win  = (byte_cnt >= offset) && ({1'b0, byte_cnt} < win_end);
        sreg_d  = sreg_q;
        if (clear) begin
            sreg_d = 64'd0;
        end else if (accept && in_win) begin
            sreg_d = {data, sreg_q[63:8]};
        end
        // Bytes enter at the top; realign so the first byte lands at bit 0.
        rem        = 3'(4'd8 - nbytes);
        shamt      = {rem, 3'b000};
        field_next = W'(sreg_d >> shamt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= 64'd0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/pitch_cmd_builder.sv
// Byte-serial BATS PITCH decoder: frames messages by length byte, captures fields
// into shadow registers and emits one registered orderbook command per message.
module pitch_cmd_builder
    import pitch_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       cmd_type,
    output logic [7:0]       cmd_side,
    output logic [63:0]      cmd_order_id,
    output logic [31:0]      cmd_quantity,
    output logic [63:0]      cmd_symbol,
    output logic [63:0]      cmd_price,
    output logic [31:0]      cmd_executed_qty,
    output logic [31:0]      cmd_cancelled_qty,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] drop_count
);
    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] type_q, type_d;
    logic       accept, take_len, start, capture, emit;
    logic [1:0] drop_inc;
    msg_info_t  info;

    logic [63:0] id_f, price_f;
    logic [7:0]  side_f;
    logic [31:0] qty_f;
    logic [47:0] sym_f;
    logic        is_add;

    assign in_ready = !cmd_valid && !reset;
    assign accept   = in_valid && in_ready;
    assign is_add   = (type_q == CmdAdd);
    assign info     = msg_lookup(in_data);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        take_len = 1'b0;
        capture  = 1'b0;
        emit     = 1'b0;
        drop_inc = 2'd0;
        if (accept) begin
            unique case (state_q)
                StIdle:   take_len = 1'b1;
                StResync: take_len = in_sof;
                StType: begin
                    if (in_sof) begin
                        take_len = 1'b1;
                        drop_inc = 2'd1;
                    end else if (info.ok && info.len == len_q) begin
                        type_d  = info.cmd;
                        cnt_d   = 8'd2;
                        state_d = StBody;
                    end else begin
                        drop_inc = 2'd1;
                        cnt_d    = 8'd2;
                        // A 2-byte message has no body left to skip.
                        state_d  = (len_q == 8'd2) ? StIdle : StSkip;
                    end
                end
                StBody, StSkip: begin
                    if (in_sof) begin
                        take_len = 1'b1;
                        drop_inc = 2'd1;
                    end else begin
                        capture = (state_q == StBody);
                        if (cnt_q == len_q - 8'd1) begin
                            emit    = (state_q == StBody);
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            if (take_len) begin
                len_d = in_data;
                cnt_d = 8'd1;
                if (in_data < 8'd2) begin
                    state_d  = StResync;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    state_d = StType;
                end
            end
        end
    end

    assign start = take_len;

    pitch_le_field_capture #(.W(64)) u_id (
        .clk(clk), .reset(reset), .clear(start), .accept(capture), .byte_cnt(cnt_q),
        .offset(OffOrderId), .nbytes(4'd8), .data(in_data), .field_next(id_f)
    );
    pitch_le_field_capture #(.W(8)) u_side (
        .clk(clk), .reset(reset), .clear(start), .accept(capture), .byte_cnt(cnt_q),
        .offset(OffAddSide), .nbytes(4'd1), .data(in_data), .field_next(side_f)
    );
    pitch_le_field_capture #(.W(32)) u_qty (
        .clk(clk), .reset(reset), .clear(start), .accept(capture), .byte_cnt(cnt_q),
        .offset(is_add ? OffAddQty : OffQty), .nbytes(4'd4), .data(in_data),
        .field_next(qty_f)
    );
    pitch_le_field_capture #(.W(48)) u_sym (
        .clk(clk), .reset(reset), .clear(start), .accept(capture), .byte_cnt(cnt_q),
        .offset(OffAddSym), .nbytes(4'd6), .data(in_data), .field_next(sym_f)
    );
    pitch_le_field_capture #(.W(64)) u_price (
        .clk(clk), .reset(reset), .clear(start), .accept(capture), .byte_cnt(cnt_q),
        .offset(is_add ? OffAddPrice : OffModPrice), .nbytes(4'd8), .data(in_data),
        .field_next(price_f)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            len_q             <= 8'd0;
            cnt_q             <= 8'd0;
            type_q            <= 8'd0;
            cmd_valid         <= 1'b0;
            cmd_type          <= 8'd0;
            cmd_side          <= 8'd0;
            cmd_order_id      <= 64'd0;
            cmd_quantity      <= 32'd0;
            cmd_symbol        <= 64'd0;
            cmd_price         <= 64'd0;
            cmd_executed_qty  <= 32'd0;
            cmd_cancelled_qty <= 32'd0;
            msg_count         <= '0;
            drop_count        <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            type_q     <= type_d;
            drop_count <= drop_count + CNT_W'(drop_inc);
            if (emit) begin
                cmd_valid         <= 1'b1;
                msg_count         <= msg_count + CNT_W'(1);
                cmd_type          <= type_q;
                cmd_order_id      <= id_f;
                cmd_side          <= is_add ? side_f : 8'd0;
                cmd_quantity      <= (is_add || type_q == CmdModify) ? qty_f : 32'd0;
                // Symbol is text: first wire byte goes to the top, space-padded to 8.
                cmd_symbol        <= is_add ? {sym_f[7:0], sym_f[15:8], sym_f[23:16],
                                               sym_f[31:24], sym_f[39:32], sym_f[47:40],
                                               16'h2020} : 64'd0;
                cmd_price         <= (is_add || type_q == CmdModify) ? price_f : 64'd0;
                cmd_executed_qty  <= (type_q == CmdExecuted) ? qty_f : 32'd0;
                cmd_cancelled_qty <= (type_q == CmdReduce) ? qty_f : 32'd0;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pitch_cmd_builder.sv
// Directed bench for pitch_cmd_builder: a table of messages with hand-computed
// commands, plus sequences for backpressure, drops, truncation, resync and reset.
module tb_pitch_cmd_builder;

    logic        clk, reset;
    logic        in_valid, in_sof, in_ready;
    logic [7:0]  in_data;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_type, cmd_side;
    logic [63:0] cmd_order_id, cmd_symbol, cmd_price;
    logic [31:0] cmd_quantity, cmd_executed_qty, cmd_cancelled_qty;
    logic [15:0] msg_count, drop_count;

    pitch_cmd_builder #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_side(cmd_side), .cmd_order_id(cmd_order_id),
        .cmd_quantity(cmd_quantity), .cmd_symbol(cmd_symbol), .cmd_price(cmd_price),
        .cmd_executed_qty(cmd_executed_qty), .cmd_cancelled_qty(cmd_cancelled_qty),
        .msg_count(msg_count), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [63:0] id;
        logic [7:0]  side;
        logic [31:0] qty;
        logic [47:0] sym;
        logic [63:0] price;
        logic [31:0] exec;
        logic [31:0] cxl;
        logic [7:0]  e_type;
        logic [7:0]  e_side;
        logic [31:0] e_qty;
        logic [63:0] e_sym;
        logic [63:0] e_price;
        logic [31:0] e_exec;
        logic [31:0] e_cxl;
    } vec_t;

    typedef struct {
        logic [7:0]  typ;
        logic [7:0]  side;
        logic [63:0] id;
        logic [31:0] qty;
        logic [63:0] sym;
        logic [63:0] price;
        logic [31:0] exec;
        logic [31:0] cxl;
    } cmd_t;

    vec_t       vecs[6];
    cmd_t       got_q[$];
    logic [7:0] tx_q[$];
    bit         sof_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         valid_cycles = 0;

    always @(posedge clk) begin
        if (cmd_valid) valid_cycles++;
        if (cmd_valid && cmd_ready)
            got_q.push_back('{cmd_type, cmd_side, cmd_order_id, cmd_quantity, cmd_symbol,
                              cmd_price, cmd_executed_qty, cmd_cancelled_qty});
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic void push_b(input logic [7:0] d, input bit s);
        tx_q.push_back(d);
        sof_q.push_back(s);
    endfunction

    function automatic void push_le(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) push_b(v[8*i +: 8], 1'b0);
    endfunction

    // Serialise one message in wire format, appending to tx_q.
    function automatic void build(input vec_t v, input bit sof);
        case (v.code)
            8'h21:   push_b(8'd34, sof);
            8'h23:   push_b(8'd26, sof);
            8'h25:   push_b(8'd18, sof);
            8'h27:   push_b(8'd27, sof);
            default: push_b(8'd14, sof);
        endcase
        push_b(v.code, 1'b0);
        push_le(64'h5D5C5B5A, 4);
        push_le(v.id, 8);
        case (v.code)
            8'h21: begin
                push_b(v.side, 1'b0);
                push_le({32'd0, v.qty}, 4);
                for (int i = 5; i >= 0; i--) push_b(v.sym[8*i +: 8], 1'b0);
                push_le(v.price, 8);
                push_b(8'h01, 1'b0);
            end
            8'h23: begin
                push_le({32'd0, v.exec}, 4);
                push_le(64'hEEEE_EEEE_EEEE_EEEE, 8);
            end
            8'h25: push_le({32'd0, v.cxl}, 4);
            8'h27: begin
                push_le({32'd0, v.qty}, 4);
                push_le(v.price, 8);
                push_b(8'h01, 1'b0);
            end
            default: ;
        endcase
    endfunction

    function automatic vec_t del_vec(input logic [63:0] id);
        vec_t v;
        v = '{8'h29, id, 8'h0, 32'h0, 48'h0, 64'h0, 32'h0, 32'h0,
              8'd4, 8'h0, 32'h0, 64'h0, 64'h0, 32'h0, 32'h0};
        return v;
    endfunction

    task automatic drive(input logic [7:0] d, input bit s);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        while (!in_ready && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_q.size(); i++) drive(tx_q[i], sof_q[i]);
        tx_q.delete();
        sof_q.delete();
    endtask

    task automatic get_cmd(input string name, output cmd_t c);
        int budget;
        budget = 0;
        while (got_q.size() == 0 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (got_q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: no command seen, required one within 200 cycles", name);
            c = '{8'hFF, 8'hFF, 64'hFFFF, 32'hFFFF, 64'hFFFF, 64'hFFFF, 32'hFFFF, 32'hFFFF};
        end else begin
            c = got_q.pop_front();
        end
    endtask

    cmd_t        c;
    logic [63:0] hold_id;
    logic [7:0]  hold_type;
    bit          stable, rdy_seen;
    logic [15:0] d0, m0;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b1;

        vecs[0] = '{8'h21, 64'h0102030405060708, 8'h42, 32'd100, 48'h4141504C2020,
                    64'd1500000, 32'h0, 32'h0,
                    8'd0, 8'h42, 32'h64, 64'h4141504C20202020, 64'h16E360, 32'h0, 32'h0};
        vecs[1] = '{8'h23, 64'h7, 8'h0, 32'h0, 48'h0, 64'h0, 32'd25, 32'h0,
                    8'd1, 8'h0, 32'h0, 64'h0, 64'h0, 32'h19, 32'h0};
        vecs[2] = '{8'h25, 64'h11, 8'h0, 32'h0, 48'h0, 64'h0, 32'h0, 32'd40,
                    8'd2, 8'h0, 32'h0, 64'h0, 64'h0, 32'h0, 32'h28};
        vecs[3] = '{8'h27, 64'hABCDEF, 8'h0, 32'd300, 48'h0, 64'h123456789, 32'h0, 32'h0,
                    8'd3, 8'h0, 32'h12C, 64'h0, 64'h123456789, 32'h0, 32'h0};
        vecs[4] = '{8'h29, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0, 32'h0, 48'h0, 64'h0, 32'h0, 32'h0,
                    8'd4, 8'h0, 32'h0, 64'h0, 64'h0, 32'h0, 32'h0};
        vecs[5] = '{8'h21, 64'h8877665544332211, 8'h53, 32'hDEADBEEF, 48'h4D5346542020,
                    64'hFEDCBA9876543210, 32'h0, 32'h0,
                    8'd0, 8'h53, 32'hDEADBEEF, 64'h4D53465420202020, 64'hFEDCBA9876543210,
                    32'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("reset_msg_count", {48'd0, msg_count}, 64'd0);
        chk("reset_order_id", cmd_order_id, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Table: only the first message carries in_sof; the rest are length-framed.
        for (int i = 0; i < 6; i++) begin
            build(vecs[i], (i == 0));
            send_all();
            get_cmd($sformatf("v%0d_cmd", i), c);
            chk($sformatf("v%0d_type", i), {56'd0, c.typ}, {56'd0, vecs[i].e_type});
            chk($sformatf("v%0d_side", i), {56'd0, c.side}, {56'd0, vecs[i].e_side});
            chk($sformatf("v%0d_id", i), c.id, vecs[i].id);
            chk($sformatf("v%0d_qty", i), {32'd0, c.qty}, {32'd0, vecs[i].e_qty});
            chk($sformatf("v%0d_sym", i), c.sym, vecs[i].e_sym);
            chk($sformatf("v%0d_price", i), c.price, vecs[i].e_price);
            chk($sformatf("v%0d_exec", i), {32'd0, c.exec}, {32'd0, vecs[i].e_exec});
            chk($sformatf("v%0d_cxl", i), {32'd0, c.cxl}, {32'd0, vecs[i].e_cxl});
        end
        repeat (3) @(posedge clk);
        #1;
        chk("table_msg_count", {48'd0, msg_count}, 64'd6);
        chk("table_valid_cycles", valid_cycles, 64'd6);
        chk("table_drop_count", {48'd0, drop_count}, 64'd0);

        // Backpressure: Delete then Reduce back to back, orderbook stalled 10 cycles.
        cmd_ready = 1'b0;
        build(del_vec(64'd5), 1'b1);
        build('{8'h25, 64'd5, 8'h0, 32'h0, 48'h0, 64'h0, 32'h0, 32'd40,
                8'd2, 8'h0, 32'h0, 64'h0, 64'h0, 32'h0, 32'h28}, 1'b0);
        fork
            send_all();
            begin : bp_watch
                int b;
                b = 0;
                while (!cmd_valid && b < 300) begin
                    @(posedge clk);
                    #1;
                    b++;
                end
                hold_id   = cmd_order_id;
                hold_type = cmd_type;
                stable    = 1'b1;
                rdy_seen  = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (cmd_order_id !== hold_id || cmd_type !== hold_type || !cmd_valid)
                        stable = 1'b0;
                    if (in_ready) rdy_seen = 1'b1;
                end
                chk("bp_stable", {63'd0, stable}, 64'd1);
                chk("bp_in_ready_low", {63'd0, rdy_seen}, 64'd0);
                chk("bp_held_type", {56'd0, cmd_type}, 64'd4);
                chk("bp_held_id", cmd_order_id, 64'd5);
                cmd_ready = 1'b1;
            end
        join
        get_cmd("bp_first", c);
        chk("bp_first_type", {56'd0, c.typ}, 64'd4);
        get_cmd("bp_second", c);
        chk("bp_second_type", {56'd0, c.typ}, 64'd2);
        chk("bp_second_id", c.id, 64'd5);
        chk("bp_second_cxl", {32'd0, c.cxl}, 64'd40);

        // Unknown type 0x3B (len 10) is skipped, then an Order Executed decodes.
        d0 = drop_count;
        push_b(8'd10, 1'b1);
        push_b(8'h3B, 1'b0);
        for (int i = 0; i < 8; i++) push_b(8'h29, 1'b0);
        build('{8'h23, 64'd7, 8'h0, 32'h0, 48'h0, 64'h0, 32'd25, 32'h0,
                8'd1, 8'h0, 32'h0, 64'h0, 64'h0, 32'h19, 32'h0}, 1'b0);
        send_all();
        get_cmd("unk_cmd", c);
        chk("unk_drop", {48'd0, drop_count - d0}, 64'd1);
        chk("unk_type", {56'd0, c.typ}, 64'd1);
        chk("unk_exec", {32'd0, c.exec}, 64'd25);

        // Truncated Modify: in_sof on byte 9 starts a Delete (id 9).
        d0 = drop_count;
        build('{8'h27, 64'hAAAA, 8'h0, 32'd1, 48'h0, 64'd2, 32'h0, 32'h0,
                8'd3, 8'h0, 32'd1, 64'h0, 64'd2, 32'h0, 32'h0}, 1'b1);
        while (tx_q.size() > 9) begin
            void'(tx_q.pop_back());
            void'(sof_q.pop_back());
        end
        build(del_vec(64'd9), 1'b1);
        send_all();
        repeat (5) @(posedge clk);
        #1;
        chk("trunc_ncmd", got_q.size(), 64'd1);
        chk("trunc_drop", {48'd0, drop_count - d0}, 64'd1);
        get_cmd("trunc_cmd", c);
        chk("trunc_type", {56'd0, c.typ}, 64'd4);
        chk("trunc_id", c.id, 64'd9);

        // len=0 forces resync; garbage is discarded until in_sof.
        d0 = drop_count;
        push_b(8'd0, 1'b0);
        for (int i = 0; i < 5; i++) push_b(8'h0E, 1'b0);
        build(del_vec(64'h33), 1'b1);
        send_all();
        repeat (5) @(posedge clk);
        #1;
        chk("resync_ncmd", got_q.size(), 64'd1);
        chk("resync_drop", {48'd0, drop_count - d0}, 64'd1);
        get_cmd("resync_cmd", c);
        chk("resync_type", {56'd0, c.typ}, 64'd4);
        chk("resync_id", c.id, 64'h33);

        // Reset mid-body of an Add Order.
        m0 = msg_count;
        chk("pre_reset_msg_nonzero", {63'd0, (m0 != 16'd0)}, 64'd1);
        build(vecs[0], 1'b1);
        for (int i = 0; i < 15; i++) drive(tx_q[i], sof_q[i]);
        tx_q.delete();
        sof_q.delete();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_msg_count", {48'd0, msg_count}, 64'd0);
        chk("rst_drop_count", {48'd0, drop_count}, 64'd0);
        chk("rst_order_id", cmd_order_id, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
        build(del_vec(64'h44), 1'b1);
        send_all();
        get_cmd("rst_after_cmd", c);
        chk("rst_after_type", {56'd0, c.typ}, 64'd4);
        chk("rst_after_id", c.id, 64'h44);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_after_msg_count", {48'd0, msg_count}, 64'd1);
        chk("rst_no_extra_cmd", got_q.size(), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
